// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: fetch bundle (PC in, stall out, imem req/gnt/rvalid, decode valid/ready); master = fetch controller, slave = PC reg/imem/decode side
interface ifetch_ctrl_if;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        pc_stall_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  modport master (
    input  pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    output pc_stall_o, imem_req_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o
  );
  modport slave (
    output pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    input  pc_stall_o, imem_req_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: one-outstanding imem fetcher feeding a DEPTH-entry {pc,inst} queue to decode; ports clk, rst (sync high), bus (ifetch_ctrl_if.master)
module ifetch_ctrl #(
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  ifetch_ctrl_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_d;
  logic [CW-1:0] count_q, count_d, occ;
  logic outst_q, discard_q, valid_q;
  logic [31:0] req_pc_q, inst_q, hpc_q, head_pc, head_inst;
  logic pop, push, rsp, gnt, issue, head_new;
  assign pop = valid_q & bus.id_ready_i;
  assign occ = count_q + CW'(outst_q);
  // a returning response frees the outstanding slot in the same cycle
  assign issue = ~rst & ~bus.flush_i & (~outst_q | bus.imem_rvalid_i) &
                 (occ < CW'(DEPTH) | (occ == CW'(DEPTH) & pop));
  assign bus.imem_req_o = issue;
  assign bus.imem_addr_o = bus.pc_i & ~32'h3;
  assign gnt = issue & bus.imem_gnt_i;
  assign bus.pc_stall_o = ~gnt;
  assign rsp = bus.imem_rvalid_i & outst_q;
  assign push = rsp & ~discard_q & ~bus.flush_i;
  assign count_d = bus.flush_i ? '0 : count_q + CW'(push) - CW'(pop);
  assign rd_d = rd_q + AW'(pop);
  // next head is the word being written when it lands exactly at the new read slot
  assign head_new = push & (rd_d == wr_q);
  assign head_pc = head_new ? req_pc_q : pc_mem[rd_d];
  assign head_inst = head_new ? bus.imem_rdata_i : inst_mem[rd_d];
  assign bus.id_valid_o = valid_q;
  assign bus.id_inst_o = inst_q;
  assign bus.id_pc_o = hpc_q;
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q] <= req_pc_q;
      inst_mem[wr_q] <= bus.imem_rdata_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      outst_q <= 1'b0;
      discard_q <= 1'b0;
      req_pc_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      valid_q <= 1'b0;
      inst_q <= NOP;
      hpc_q <= '0;
    end else begin
      count_q <= count_d;
      outst_q <= gnt | (outst_q & ~rsp);
      discard_q <= (bus.flush_i & outst_q & ~bus.imem_rvalid_i) | (discard_q & ~rsp);
      if (gnt) req_pc_q <= bus.imem_addr_o;
      rd_q <= bus.flush_i ? '0 : rd_d;
      wr_q <= bus.flush_i ? '0 : wr_q + AW'(push);
      valid_q <= count_d != '0;
      inst_q <= count_d != '0 ? head_inst : NOP;
      hpc_q <= count_d != '0 ? head_pc : '0;
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed fetch scenarios with a scoreboard of hand-listed PCs checked by a decode-side monitor
module tb_ifetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  ifetch_ctrl_if bus ();
  ifetch_ctrl #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, cyc = 0, npop = 0;
  int budget = 0, gnt_delay = 0, wait_cnt = 0, rv_lat = 1, rv_cnt = 0;
  int first_g = -1, first_v = -1;
  bit spur = 1'b0;
  logic [31:0] p_addr = '0;
  logic s_req, s_stall, s_valid, fire;
  logic [31:0] s_addr, s_inst, s_pc;
  logic [63:0] exp_q [$];
  logic [63:0] e;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'd9) ^ 32'h0BAD_0033;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask
  task automatic expect_pc(input logic [31:0] a);
    exp_q.push_back({a, mem_f(a)});
  endtask
  task automatic step(input bit fl = 1'b0, input logic [31:0] tgt = '0);
    bit rv;
    @(negedge clk);
    #1;
    rv = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      rv = (rv_cnt == 0);
    end
    bus.flush_i = fl;
    bus.imem_rvalid_i = rv | spur;
    bus.imem_rdata_i = rv ? mem_f(p_addr) : 32'hDEAD_BEEF;
    #1;
    bus.imem_gnt_i = bus.imem_req_o && budget > 0 && wait_cnt >= gnt_delay;
    #2;
    s_req = bus.imem_req_o;
    s_stall = bus.pc_stall_o;
    s_addr = bus.imem_addr_o;
    s_valid = bus.id_valid_o;
    s_inst = bus.id_inst_o;
    s_pc = bus.id_pc_o;
    fire = bus.imem_req_o & bus.imem_gnt_i;
    @(posedge clk);
    #1;
    if (fire) begin
      if (first_g < 0) first_g = cyc;
      rv_cnt = rv_lat;
      p_addr = s_addr;
      budget--;
      wait_cnt = 0;
    end else if (s_req) wait_cnt++;
    cyc++;
    if (fl) bus.pc_i = tgt;
    else if (!s_stall) bus.pc_i = bus.pc_i + 32'd4;
    bus.flush_i = 1'b0;
    bus.imem_gnt_i = 1'b0;
  endtask
  always @(negedge clk) begin
    #3;
    if (!rst && bus.id_valid_o && first_v < 0) first_v = cyc;
    if (!rst && bus.id_valid_o && bus.id_ready_i) begin
      npop++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h inst %h expected no instruction", bus.id_pc_o, bus.id_inst_o);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", bus.id_pc_o, e[63:32]);
        chk("id_inst", bus.id_inst_o, e[31:0]);
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.pc_i = '0;
    bus.flush_i = 1'b0;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.id_ready_i = 1'b0;
    step();
    step();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_stall", 32'(s_stall), 32'd1);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_inst", s_inst, 32'h0000_0013);
    chk("rst_pc", s_pc, 32'd0);
    rst = 1'b0;
    bus.id_ready_i = 1'b1;
    budget = 4;
    for (int a = 0; a < 16; a += 4) expect_pc(32'(a));
    step();
    chk("first_req", 32'(s_req), 32'd1);
    chk("first_addr", s_addr, 32'd0);
    repeat (5) step();
    chk("throughput_pops", 32'(npop), 32'd4);
    chk("latency", 32'(first_v - first_g), 32'd2);
    repeat (3) step();
    chk("drain_stream", 32'(exp_q.size()), 32'd0);
    for (int a = 'h10; a <= 'h24; a += 4) expect_pc(32'(a));
    bus.id_ready_i = 1'b0;
    budget = 6;
    repeat (5) step();
    chk("bp_req", 32'(s_req), 32'd0);
    chk("bp_stall", 32'(s_stall), 32'd1);
    chk("bp_valid", 32'(s_valid), 32'd1);
    chk("bp_head", s_pc, 32'h10);
    bus.id_ready_i = 1'b1;
    repeat (14) step();
    chk("drain_bp", 32'(exp_q.size()), 32'd0);
    budget = 1;
    rv_lat = 2;
    step();
    chk("f1_addr", s_addr, 32'h28);
    chk("f1_grant", 32'(s_stall), 32'd0);
    step(1'b1, 32'h100);
    chk("flush_noreq", 32'(s_req), 32'd0);
    budget = 3;
    rv_lat = 1;
    for (int a = 'h100; a <= 'h108; a += 4) expect_pc(32'(a));
    repeat (10) step();
    chk("drain_f1", 32'(exp_q.size()), 32'd0);
    bus.id_ready_i = 1'b0;
    budget = 2;
    step();
    step();
    step(1'b1, 32'h200);
    chk("f2_valid_pre", 32'(s_valid), 32'd1);
    step();
    chk("f2_valid", 32'(s_valid), 32'd0);
    budget = 2;
    bus.id_ready_i = 1'b1;
    expect_pc(32'h200);
    expect_pc(32'h204);
    repeat (8) step();
    chk("drain_f2", 32'(exp_q.size()), 32'd0);
    gnt_delay = 3;
    wait_cnt = 0;
    budget = 2;
    expect_pc(32'h208);
    expect_pc(32'h20C);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("slow_req", 32'(s_req), 32'd1);
      chk("slow_addr", s_addr, 32'h208);
      chk("slow_stall", 32'(s_stall), 32'd1);
    end
    step();
    chk("slow_gnt", 32'(s_stall), 32'd0);
    chk("slow_pc", bus.pc_i, 32'h20C);
    repeat (10) step();
    chk("drain_slow", 32'(exp_q.size()), 32'd0);
    gnt_delay = 0;
    spur = 1'b1;
    step();
    step();
    spur = 1'b0;
    step();
    chk("spur_valid", 32'(s_valid), 32'd0);
    budget = 2;
    bus.id_ready_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_req", 32'(s_req), 32'd0);
    chk("mid_rst_stall", 32'(s_stall), 32'd1);
    bus.pc_i = 32'h300;
    rst = 1'b0;
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("post_rst_valid", 32'(s_valid), 32'd0);
    chk("post_rst_inst", s_inst, 32'h0000_0013);
    chk("post_rst_pc", s_pc, 32'd0);
    budget = 2;
    bus.id_ready_i = 1'b1;
    expect_pc(32'h300);
    expect_pc(32'h304);
    repeat (8) step();
    chk("final_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
